// File: rtl/mem_reader_if.sv
// RAM port bundle for the 32x4 asynchronous RAM on the cs/we/oe bus.
// The reader is the master; the RAM (or its model) is the slave.
interface mem_reader_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 4
);
    logic [ADDR_W-1:0] address;
    logic              cs;
    logic              we;
    logic              oe;
    logic [DATA_W-1:0] data;

    modport master (output address, cs, we, oe, input data);
    modport slave  (input address, cs, we, oe, output data);
endinterface

// File: rtl/mem_reader.sv
// Read-back sweep of the whole RAM with cs/oe strobes, comparing each word
// against (address + SEED) and counting mismatches.
module mem_reader #(
    parameter int ADDR_W      = 5,
    parameter int DATA_W      = 4,
    parameter int SEED        = 0,
    parameter int WAIT_CYCLES = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    mem_reader_if.master      bus,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   err_count,
    output logic              err_flag,
    output logic [ADDR_W-1:0] first_err_addr
);
    typedef enum logic [2:0] {IDLE, SETUP, STROBE, RECOVER, DONE} state_t;

    localparam int EXT_W = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;

    state_t            state, next_state;
    logic [ADDR_W-1:0] addr_q;
    logic              cs_q, oe_q;
    logic [3:0]        wait_cnt;
    logic              accept, last_wait, last_addr, sample, mismatch;
    logic [EXT_W-1:0]  addr_ext;
    logic [DATA_W-1:0] exp_word;

    assign accept    = ((state == IDLE) || (state == DONE)) && start;
    assign last_wait = (wait_cnt == 4'(WAIT_CYCLES - 1));
    assign last_addr = &addr_q;
    assign sample    = (state == STROBE) && last_wait;
    // Zero-extend so the low DATA_W bits exist even for a narrow address.
    assign addr_ext  = EXT_W'(addr_q);
    assign exp_word  = addr_ext[DATA_W-1:0] + DATA_W'(SEED);
    assign mismatch  = (bus.data != exp_word);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= IDLE;
            addr_q         <= '0;
            cs_q           <= 1'b0;
            oe_q           <= 1'b0;
            wait_cnt       <= '0;
            err_count      <= '0;
            err_flag       <= 1'b0;
            first_err_addr <= '0;
        end else begin
            state <= next_state;
            // Strobes are registered from the next state so they are glitch-free.
            cs_q  <= (next_state == SETUP) || (next_state == STROBE) ||
                     (next_state == RECOVER);
            oe_q  <= (next_state == STROBE);

            if (state != STROBE)
                wait_cnt <= '0;
            else if (!last_wait)
                wait_cnt <= wait_cnt + 1'b1;

            if (accept)
                addr_q <= '0;
            else if ((state == RECOVER) && !last_addr)
                addr_q <= addr_q + 1'b1;

            if (accept) begin
                err_count      <= '0;
                err_flag       <= 1'b0;
                first_err_addr <= '0;
            end else if (sample && mismatch) begin
                err_count <= err_count + 1'b1;
                err_flag  <= 1'b1;
                if (!err_flag)
                    first_err_addr <= addr_q;
            end
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = SETUP;
            SETUP:   next_state = STROBE;
            STROBE:  if (last_wait) next_state = RECOVER;
            RECOVER: next_state = last_addr ? DONE : SETUP;
            DONE:    if (start) next_state = SETUP;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        bus.address = addr_q;
        bus.cs      = cs_q;
        bus.oe      = oe_q;
        bus.we      = 1'b0;
        busy        = (state == SETUP) || (state == STROBE) || (state == RECOVER);
        done        = (state == DONE);
    end
endmodule

// File: doc/mem_reader.md
# mem_reader

Clocked read-back initiator for the 32x4 asynchronous RAM on the cs/we/oe bus. On `start` it sweeps addresses 0 to 31 with read strobes only. It samples the RAM's data output and compares each word against a parameterised expected pattern, counting mismatches. It complements the existing write-side memory FSM and connects to the same RAM port: it drives `address`, `cs`, `we` and `oe`, and receives `data`.

## Interface
- `ADDR_W`, default 5: address width; sweep covers 0 to 2^ADDR_W−1.
- `DATA_W`, default 4: data width.
- `SEED`, default 0: expected word = (address[DATA_W-1:0] + SEED) mod 2^DATA_W.
- `WAIT_CYCLES`, default 1, range 1..15: number of cycles `oe` stays asserted before sampling.

Ports:
- `clk`, input, 1: single clock; all state changes on the rising edge.
- `reset`, input, 1: asynchronous, active-low reset.
- `start`, input, 1: begin a sweep; sampled in IDLE and DONE only.
- `data`, input, DATA_W: RAM read data; valid while `cs`=1 and `oe`=1.
- `address`, output, ADDR_W: RAM address (registered).
- `cs`, output, 1: chip select (registered).
- `we`, output, 1: write enable; constant 0.
- `oe`, output, 1: output enable (registered).
- `busy`, output, 1: high in SETUP, STROBE and RECOVER.
- `done`, output, 1: level; high in DONE.
- `err_count`, output, ADDR_W+1: number of mismatches in the current or last sweep (0..32).
- `err_flag`, output, 1: at least one mismatch in the current or last sweep.
- `first_err_addr`, output, ADDR_W: address of the first mismatch; meaningful only when `err_flag`=1.

## Operation
- States: IDLE, SETUP, STROBE, RECOVER, DONE.
- **IDLE:** cs=oe=0.
  - start=1 → SETUP.
  - On that edge: address=0; err_count, err_flag and first_err_addr cleared; wait counter cleared.
- **SETUP:** cs=1, oe=0, for 1 cycle, so the address is stable before the strobe. → STROBE.
- **STROBE:** cs=1, oe=1, for WAIT_CYCLES cycles.
  - On the rising edge that ends the last STROBE cycle, `data` is compared with the expected word.
  - On mismatch: err_count+1; err_flag set; first_err_addr loaded if err_flag was 0.
  - → RECOVER.
- **RECOVER:** cs=1, oe=0, for 1 cycle (bus turnaround).
  - If address = 2^ADDR_W−1 → DONE, with address held.
  - Otherwise address+1 → SETUP.
- **DONE:** cs=oe=0, done=1, results held.
  - start=1 → SETUP, with the same clears as from IDLE.
  - Otherwise stay in DONE.
- `start` is ignored while busy=1.
- `we` is never asserted; the block never drives `data`.
- Address increment never wraps inside a sweep: the terminal address exits to DONE.
- err_count cannot overflow: maximum 2^ADDR_W, and the width is ADDR_W+1.

## Timing
- Reset (reset=0, asynchronous): state=IDLE.
  - All outputs 0: address=0, cs=0, we=0, oe=0, busy=0, done=0, err_count=0, err_flag=0, first_err_addr=0.
  - Reset asserted mid-sweep aborts immediately, with no partial-result hold.
  - After release, the block waits in IDLE for `start`.
- Cycles per word: WAIT_CYCLES+2.
- Define cycle 0 as the cycle whose ending edge samples start=1 in IDLE.
  - Word n occupies cycles n·(W+2)+1 .. (n+1)·(W+2), where W = WAIT_CYCLES.
  - done rises in cycle 32·(W+2)+1, which is 97 for W=1.
- `oe` is never high without `cs` high.
- `oe` is always low for at least 1 cycle between consecutive words.
- `cs` never drops between words within a sweep.
- The error outputs update on the sampling edge and are visible the next cycle, during RECOVER.

## Test plan
- **Clean memory.** Preload the RAM with (addr+0) mod 16, reset, pulse start.
  - Response: 32 STROBE windows at addresses 0..31 in order; done=1 at cycle 97; err_count=0; err_flag=0; we=0 throughout.
- **Single fault.** Same preload, but RAM[13]=4'hF.
  - Response: err_count=1; err_flag=1; first_err_addr=13.
- **Multiple faults.** Corrupt addresses 2, 7 and 31.
  - Response: err_count=3; first_err_addr=2; the error at address 31 is counted before done rises.
- **SEED and WAIT_CYCLES.** SEED=5, WAIT_CYCLES=3, RAM holds (addr+5) mod 16.
  - Response: err_count=0; oe high for 3 consecutive cycles per word; done at cycle 161.
- **Start handling.** Pulse start mid-sweep at address 10, then again in DONE.
  - Response: the mid-sweep pulse is ignored and the sweep continues to 31.
  - The pulse in DONE restarts at address 0, with err_count cleared on the accepting edge.
- **Reset mid-operation.** Assert reset=0 during STROBE at address 20.
  - Response: same cycle, all outputs 0 and state IDLE.
  - After release, no bus activity until start.
